// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: reset sequencer between a PLL LOCKED output and the
// downstream per-domain reset synchronisers. Runs in the reference clock domain.
// It pulses the PLL reset and waits for a stable lock, with timeout and retry.
// It then holds the downstream reset for a while before releasing it.
// It re-asserts the downstream reset on loss of lock.
// Optional feature macro: LOSS_COUNT_EN. When defined, loss_cnt is a saturating
// count of lock losses seen in RUN. When undefined, loss_cnt is tied to zero.
module pll_lock_rst_seq #(
    parameter int unsigned PLL_RST_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT   = 1024,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned LOSS_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    output logic              pll_rst,
    output logic              rst_out,
    output logic              ready,
    output logic [LOSS_W-1:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // Terminal timer values: the timer starts at 0 on state entry, so a state
    // that must last N cycles leaves when the timer reads N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] timer_r;
    logic             locked_meta_r;
    logic             locked_s;

    // Two-flop synchroniser bringing the asynchronous LOCKED into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_meta_r <= 1'b0;
            locked_s      <= 1'b0;
        end else begin
            locked_meta_r <= locked;
            locked_s      <= locked_meta_r;
        end
    end

    // Sequencer FSM and its shared state timer; loss of lock always wins over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_PLL_RST;
            timer_r <= TIMER_ZERO;
        end else begin
            case (state_r)
                ST_PLL_RST: begin
                    if (timer_r == PLL_RST_LAST) begin
                        state_r <= ST_WAIT_LOCK;
                        timer_r <= TIMER_ZERO;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_r <= ST_STABLE;
                        timer_r <= TIMER_ZERO;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_r <= ST_PLL_RST;
                        timer_r <= TIMER_ZERO;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                        timer_r <= TIMER_ZERO;
                    end else if (timer_r == STABLE_LAST) begin
                        state_r <= ST_HOLD;
                        timer_r <= TIMER_ZERO;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                        timer_r <= TIMER_ZERO;
                    end else if (timer_r == HOLD_LAST) begin
                        state_r <= ST_RUN;
                        timer_r <= TIMER_ZERO;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_RUN: begin
                    // The timer is idle in RUN and parked at zero.
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                    end else begin
                        state_r <= ST_RUN;
                    end
                    timer_r <= TIMER_ZERO;
                end
                default: begin
                    state_r <= ST_PLL_RST;
                    timer_r <= TIMER_ZERO;
                end
            endcase
        end
    end

    // Registered output decode of the state register; no input reaches an output directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_rst <= 1'b1;
            rst_out <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state_r)
                ST_PLL_RST: begin
                    pll_rst <= 1'b1;
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                end
                ST_WAIT_LOCK, ST_STABLE, ST_HOLD: begin
                    pll_rst <= 1'b0;
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                end
                ST_RUN: begin
                    pll_rst <= 1'b0;
                    rst_out <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    pll_rst <= 1'b1;
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_cnt_r;
    logic              loss_event_s;

    assign loss_event_s = (state_r == ST_RUN) && !locked_s;

    // Saturating counter of RUN -> WAIT_LOCK transitions caused by lock loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_r <= {LOSS_W{1'b0}};
        end else if (loss_event_s && (loss_cnt_r != {LOSS_W{1'b1}})) begin
            loss_cnt_r <= loss_cnt_r + LOSS_W'(1);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`else
    assign loss_cnt = {LOSS_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq: startup latency, lock loss in RUN,
// loss-counter saturation, STABLE glitch restart, reset pulse in RUN, and lock timeout retry.
`timescale 1ns/1ps
module tb_pll_lock_rst_seq;

    localparam int LOSS_W = 2;
`ifdef LOSS_COUNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              locked;
    logic              pll_rst;
    logic              rst_out;
    logic              ready;
    logic [LOSS_W-1:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_rst_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (16),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (16),
        .CNT_W         (16),
        .LOSS_W        (LOSS_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .pll_rst (pll_rst),
        .rst_out (rst_out),
        .ready   (ready),
        .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    function automatic int exp_loss(input int k);
        if (LOSS_EN == 0) return 0;
        return (k > 3) ? 3 : k;
    endfunction

    // Drop locked for 5 edges while in RUN, then let the sequencer recover to RUN.
    task automatic lose_and_recover(input int k);
        locked = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            tick();
            chk("loss_rst_out", {31'd0, rst_out}, (i >= 3 && i < 32) ? 32'd1 : 32'd0);
            chk("loss_ready", {31'd0, ready}, (i >= 3 && i < 32) ? 32'd0 : 32'd1);
            chk("loss_cnt", {30'd0, loss_cnt}, (i >= 2) ? exp_loss(k) : exp_loss(k - 1));
            if (i == 4) locked = 1'b1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b1;
        repeat (3) tick();
        chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("rst_rst_out", {31'd0, rst_out}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_loss", {30'd0, loss_cnt}, 32'd0);

        // Startup with lock present: rst_out falls 29 cycles after release.
        rst = 1'b0;
        for (int i = 0; i <= 29; i++) begin
            tick();
            chk("start_pll_rst", {31'd0, pll_rst}, (i < 4) ? 32'd1 : 32'd0);
            chk("start_rst_out", {31'd0, rst_out}, (i < 29) ? 32'd1 : 32'd0);
            chk("start_ready", {31'd0, ready}, (i >= 29) ? 32'd1 : 32'd0);
        end
        chk("start_loss", {30'd0, loss_cnt}, 32'd0);

        // Five lock losses in RUN; the 2-bit counter saturates at 3.
        for (int k = 1; k <= 5; k++) lose_and_recover(k);

        // One-cycle reset in RUN, then a one-cycle lock glitch during STABLE.
        rst = 1'b1;
        tick();
        chk("srst_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("srst_rst_out", {31'd0, rst_out}, 32'd1);
        chk("srst_ready", {31'd0, ready}, 32'd0);
        chk("srst_loss", {30'd0, loss_cnt}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i <= 34; i++) begin
            tick();
            chk("glitch_pll_rst", {31'd0, pll_rst}, (i < 4) ? 32'd1 : 32'd0);
            chk("glitch_rst_out", {31'd0, rst_out}, (i < 34) ? 32'd1 : 32'd0);
            chk("glitch_ready", {31'd0, ready}, (i >= 34) ? 32'd1 : 32'd0);
            if (i == 5) locked = 1'b0;
            if (i == 6) locked = 1'b1;
        end

        // No lock at all: 4-cycle PLL reset pulses every 20 cycles, never ready.
        locked = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("tmo_pll_rst", {31'd0, pll_rst}, ((i % 20) < 4) ? 32'd1 : 32'd0);
            chk("tmo_rst_out", {31'd0, rst_out}, 32'd1);
            chk("tmo_ready", {31'd0, ready}, 32'd0);
        end
        chk("tmo_loss", {30'd0, loss_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
